// File: rtl/ann_wseq_pkg.sv
// ann_wseq_pkg: sequencer states and default weight BRAM geometry shared by all weight BRAM instances
package ann_wseq_pkg;
  localparam int WSEQ_DEPTH = 28;
  localparam int WSEQ_AW = 5;
  localparam int WSEQ_DW = 16;
  typedef enum logic [2:0] {IDLE, READ, DRAIN, LOAD, DONE} wseq_state_t;
endpackage

// File: rtl/weight_skid_buf.sv
// weight_skid_buf: 2-entry valid/ready FIFO of {last, index, data} exposing its occupancy
module weight_skid_buf
  import ann_wseq_pkg::*;
#(
  parameter int W = 1 + WSEQ_AW + WSEQ_DW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         valid,
  input  logic         ready,
  output logic [1:0]   occ
);
  logic [W-1:0] mem [2];
  logic rd_ptr, wr_ptr, pop, wr;
  assign valid = occ != 2'd0;
  assign pop = valid && ready;
  assign wr = push && (occ != 2'd2 || pop);
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      occ <= 2'd0;
    end else begin
      if (wr) mem[wr_ptr] <= din;
      wr_ptr <= wr_ptr ^ wr;
      rd_ptr <= rd_ptr ^ pop;
      occ <= occ + 2'(wr) - 2'(pop);
    end
endmodule

// File: rtl/weight_bram_sequencer.sv
// weight_bram_sequencer: read-sweep / reload controller for one negedge weight BRAM.
// Define WSEQ_LOAD_EN to build the streamed reload path; otherwise the block is read-only.
module weight_bram_sequencer
  import ann_wseq_pkg::*;
#(
  parameter int DEPTH = WSEQ_DEPTH,
  parameter int AW = WSEQ_AW,
  parameter int DW = WSEQ_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          load,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_valid,
  output logic          ld_ready,
  output logic [DW-1:0] w_data,
  output logic [AW-1:0] w_index,
  output logic          w_last,
  output logic          w_valid,
  input  logic          w_ready,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] bram_addr,
  output logic [DW-1:0] bram_di,
  output logic          bram_en,
  output logic          bram_we,
  input  logic [DW-1:0] bram_do
);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  wseq_state_t st, st_n;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [1:0] occ;
  logic in_flight, pop, room, issue, load_go, wr_fire;
  assign in_flight = bram_en && !bram_we;
  assign pop = w_valid && w_ready;
  // a beat leaving this edge frees its slot, which keeps 1 word/cycle with only two entries
  assign room = 3'(occ) + 3'(in_flight) - 3'(pop) < 3'd2;
  assign busy = st != IDLE;
  assign done = st == DONE;
  weight_skid_buf #(.W(1 + AW + DW)) u_buf (
    .clk(clk),
    .rst(rst),
    .push(in_flight),
    .din({bram_addr == LAST, bram_addr, bram_do}),
    .dout({w_last, w_index, w_data}),
    .valid(w_valid),
    .ready(w_ready),
    .occ(occ)
  );
  always_comb begin
    st_n = st;
    issue = 1'b0;
    case (st)
      IDLE: begin
        st_n = load_go ? LOAD : start ? READ : IDLE;
        issue = !load_go && start;
      end
      READ: begin
        issue = room;
        st_n = room && rd_addr == LAST ? DRAIN : READ;
      end
      DRAIN: st_n = occ == 2'd0 && !in_flight ? DONE : DRAIN;
      LOAD: st_n = wr_fire && wr_addr == LAST ? DONE : LOAD;
      DONE: st_n = IDLE;
      default: st_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= IDLE;
      rd_addr <= '0;
      bram_addr <= '0;
      bram_en <= 1'b0;
    end else begin
      st <= st_n;
      bram_en <= issue || wr_fire;
      bram_addr <= issue ? rd_addr : wr_fire ? wr_addr : bram_addr;
      if (issue) rd_addr <= rd_addr == LAST ? '0 : rd_addr + AW'(1);
    end
`ifdef WSEQ_LOAD_EN
  logic [AW-1:0] wr_cnt;
  assign ld_ready = st == LOAD;
  assign wr_fire = ld_valid && ld_ready;
  assign load_go = load;
  assign wr_addr = wr_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_cnt <= '0;
      bram_we <= 1'b0;
      bram_di <= '0;
    end else begin
      bram_we <= wr_fire;
      if (wr_fire) begin
        bram_di <= ld_data;
        wr_cnt <= wr_cnt == LAST ? '0 : wr_cnt + AW'(1);
      end
    end
`else
  wire unused_ld = ^{load, ld_valid, ld_data};
  assign ld_ready = 1'b0;
  assign wr_fire = 1'b0;
  assign load_go = 1'b0;
  assign wr_addr = '0;
  assign bram_we = 1'b0;
  assign bram_di = '0;
`endif
endmodule

// File: tb/tb_weight_bram_sequencer.sv
// tb_weight_bram_sequencer: vector table plus randomized sweeps/reloads against a BRAM model and ordered-stream reference
module tb_weight_bram_sequencer;
  localparam int DEPTH = 28;
  logic clk = 0, rst = 1, start = 0, load = 0, ld_valid = 0, w_ready = 0;
  logic [15:0] ld_data = 0;
  logic ld_ready, w_last, w_valid, busy, done, bram_en, bram_we;
  logic [15:0] w_data, bram_di, bram_do = 0;
  logic [4:0] w_index, bram_addr;
  logic [15:0] mem [32];
  logic [15:0] ref_mem [DEPTH];
  logic [21:0] got [$];
  logic [21:0] held;
  logic pend = 0;
  int checks = 0, failures = 0, cyc = 0, dones = 0, done_cyc = 0, hs_cyc = 0, first_hs = 0;
  int last_acc = -1, rd_in_load = 0, we_seen = 0;
  bit in_load = 0;

  weight_bram_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .load(load), .ld_data(ld_data), .ld_valid(ld_valid),
    .ld_ready(ld_ready), .w_data(w_data), .w_index(w_index), .w_last(w_last), .w_valid(w_valid),
    .w_ready(w_ready), .busy(busy), .done(done), .bram_addr(bram_addr), .bram_di(bram_di),
    .bram_en(bram_en), .bram_we(bram_we), .bram_do(bram_do)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // negedge-clocked BRAM: writes when WE, reads only when WE=0
  always @(negedge clk)
    if (bram_en) begin
      if (bram_we) mem[bram_addr] <= bram_di;
      else bram_do <= mem[bram_addr];
    end

  // stream monitor: values seen here are the ones the next posedge samples
  always @(negedge clk)
    if (rst) pend = 0;
    else begin
      if (pend) begin
        checks++;
        if (!w_valid || {w_last, w_index, w_data} !== held) begin
          failures++;
          $display("FAIL stall hold: got v=%0b %0h expected v=1 %0h", w_valid, {w_last, w_index, w_data}, held);
        end
      end
      if (bram_en) begin
        checks++;
        if (bram_addr >= DEPTH) begin
          failures++;
          $display("FAIL addr range: got %0d expected <%0d", bram_addr, DEPTH);
        end
      end
      if (bram_en && !bram_we) begin
        checks++;
        if (int'(bram_addr) > last_acc + 2) begin
          failures++;
          $display("FAIL read ahead: got addr %0d expected <=%0d", bram_addr, last_acc + 2);
        end
        if (in_load) rd_in_load++;
      end
      if (bram_we) we_seen++;
      if (done) begin
        dones++;
        done_cyc = cyc;
      end
      if (w_valid && w_ready) begin
        if (got.size() == 0) first_hs = cyc + 1;
        got.push_back({w_last, w_index, w_data});
        last_acc = int'(w_index);
        hs_cyc = cyc + 1;
      end
      pend = w_valid && !w_ready;
      held = {w_last, w_index, w_data};
    end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_obs;
    got.delete();
    dones = 0;
    last_acc = -1;
  endtask

  task automatic check_stream(input string nm);
    chk({nm, " beats"}, got.size(), DEPTH);
    for (int i = 0; i < got.size() && i < DEPTH; i++)
      chk($sformatf("%s beat %0d", nm, i), got[i], {i == DEPTH - 1, 5'(i), ref_mem[i]});
  endtask

  task automatic finish_sweep(input string nm, input bit rnd, input bit mid_start);
    for (int n = 0; n < 600 && dones == 0; n++) begin
      w_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start = mid_start && n == 10;
      tick;
    end
    start = 0;
    w_ready = 1;
    repeat (4) tick;
    chk({nm, " done count"}, dones, 1);
    check_stream(nm);
  endtask

  task automatic run_sweep(input string nm, input bit rnd, input bit mid_start);
    int t0;
    clear_obs();
    start = 1;
    w_ready = 1;
    tick;
    t0 = cyc;
    start = 0;
    finish_sweep(nm, rnd, mid_start);
    if (!rnd) begin
      chk({nm, " first hs"}, first_hs - t0, 2);
      chk({nm, " last hs"}, hs_cyc - t0, DEPTH + 1);
      chk({nm, " done lag"}, done_cyc - hs_cyc, 1);
    end
  endtask

  typedef struct {
    logic start, ready, busy, valid, en;
    logic [4:0] idx, addr;
  } vec_t;
  vec_t tbl [9];

  initial begin
    tbl[0] = '{1, 0, 1, 0, 1, 0, 0};
    tbl[1] = '{0, 0, 1, 1, 1, 0, 1};
    tbl[2] = '{0, 0, 1, 1, 0, 0, 0};
    tbl[3] = '{0, 0, 1, 1, 0, 0, 0};
    tbl[4] = '{0, 1, 1, 1, 1, 1, 2};
    tbl[5] = '{0, 1, 1, 1, 1, 2, 3};
    tbl[6] = '{0, 1, 1, 1, 1, 3, 4};
    tbl[7] = '{0, 0, 1, 1, 0, 3, 0};
    tbl[8] = '{0, 1, 1, 1, 1, 4, 5};
    for (int i = 0; i < 32; i++) mem[i] <= 16'h0100 + 16'(i);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 16'h0100 + 16'(i);
    repeat (2) tick;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst w_valid", w_valid, 0);
    chk("rst bram_en", bram_en, 0);
    chk("rst bram_we", bram_we, 0);
    chk("rst ld_ready", ld_ready, 0);
    chk("rst bram_addr", bram_addr, 0);
    chk("rst w_data", {w_last, w_index, w_data}, 0);
    rst = 0;
    tick;

    clear_obs();
    for (int i = 0; i < 9; i++) begin
      start = tbl[i].start;
      w_ready = tbl[i].ready;
      tick;
      chk($sformatf("vec%0d busy", i), busy, tbl[i].busy);
      chk($sformatf("vec%0d w_valid", i), w_valid, tbl[i].valid);
      if (tbl[i].valid) chk($sformatf("vec%0d w_index", i), w_index, tbl[i].idx);
      chk($sformatf("vec%0d bram_en", i), bram_en, tbl[i].en);
      if (tbl[i].en) chk($sformatf("vec%0d bram_addr", i), bram_addr, tbl[i].addr);
    end
    finish_sweep("table sweep", 0, 0);

    run_sweep("full rate", 0, 0);
    run_sweep("random ready", 1, 1);
    run_sweep("random ready 2", 1, 0);

`ifdef WSEQ_LOAD_EN
    begin
      int i;
      bit v, r;
      clear_obs();
      in_load = 1;
      start = 1;
      load = 1;
      tick;
      start = 0;
      load = 0;
      chk("load busy", busy, 1);
      chk("load ld_ready", ld_ready, 1);
      chk("load w_valid", w_valid, 0);
      i = 0;
      for (int n = 0; n < 400 && i < DEPTH; n++) begin
        ld_valid = $urandom_range(0, 2) != 0;
        ld_data = 16'hA000 + 16'(i);
        v = ld_valid;
        r = ld_ready;
        tick;
        if (v && r) begin
          ref_mem[i] = 16'hA000 + 16'(i);
          i++;
        end
      end
      ld_valid = 0;
      chk("load beats", i, DEPTH);
      chk("load ready drop", ld_ready, 0);
      chk("load done", done, 1);
      repeat (3) tick;
      in_load = 0;
      chk("load done count", dones, 1);
      chk("load reads", rd_in_load, 0);
      for (int k = 0; k < DEPTH; k++) chk($sformatf("bram word %0d", k), mem[k], 16'hA000 + 16'(k));
      run_sweep("after load", 0, 0);
    end
`else
    clear_obs();
    load = 1;
    tick;
    load = 0;
    for (int n = 0; n < 4; n++) begin
      chk("ro busy", busy, 0);
      chk("ro ld_ready", ld_ready, 0);
      tick;
    end
    chk("ro writes", we_seen, 0);
    chk("ro done count", dones, 0);
`endif

    clear_obs();
    start = 1;
    w_ready = 1;
    tick;
    start = 0;
    for (int n = 0; n < 100 && got.size() < 10; n++) tick;
    chk("beats before rst", got.size(), 10);
    rst = 1;
    #1;
    chk("abort bram_en", bram_en, 0);
    chk("abort busy", busy, 0);
    chk("abort w_valid", w_valid, 0);
    chk("abort done", done, 0);
    chk("abort bram_addr", bram_addr, 0);
    chk("abort w_data", {w_last, w_index, w_data}, 0);
    repeat (2) tick;
    rst = 0;
    repeat (3) tick;
    chk("abort no done", dones, 0);
    chk("abort idle", busy, 0);
    run_sweep("restart", 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
